// File: rtl/crc.sv
// Systematic CRC encoder: 5-bit data word, degree-2 generator, 7-bit codeword.
// The GF(2) long division is combinational; only the codeword is registered.
module crc (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] msg,
    input  logic [2:0] gp,
    output logic [6:0] crcf
);

    logic [6:0] div_d;
    logic [1:0] rem_d;
    logic [6:0] crcf_d;
    logic [6:0] crcf_q;

    // MSB-first division; a generator with gp[2]=0 leaves the leading bit set,
    // which is intentional so that every gp value has a defined remainder.
    always_comb begin
        div_d = {msg[4:0], 2'b00};
        for (int i = 6; i >= 2; i--) begin
            if (div_d[i]) begin
                div_d[i -: 3] = div_d[i -: 3] ^ gp;
            end
        end
        rem_d  = div_d[1:0];
        crcf_d = {msg[4:0], rem_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crcf_q <= 7'b0000000;
        end else begin
            crcf_q <= crcf_d;
        end
    end

    assign crcf = crcf_q;

endmodule

// File: tb/tb_crc.sv
// Self-checking bench for crc: directed vectors, mid-stream reset, and random
// traffic against an integer long-division model plus linearity checks.
module tb_crc;

    logic       clk;
    logic       rst;
    logic [6:0] msg;
    logic [2:0] gp;
    logic [6:0] crcf;

    int checks = 0;
    int errors = 0;

    crc dut (
        .clk  (clk),
        .rst  (rst),
        .msg  (msg),
        .gp   (gp),
        .crcf (crcf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of (data * x^2) by gp using plain integer shifts and XOR.
    function automatic logic [6:0] ref_crc(input logic [6:0] m, input logic [2:0] g);
        int d;
        d = int'(m[4:0]) * 4;
        for (int k = 6; k >= 2; k--) begin
            if (((d >> k) & 1) == 1) d = d ^ (int'(g) << (k - 2));
        end
        return {m[4:0], 2'(d & 3)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; msg = 7'b0011111; gp = 3'b111;
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (crcf !== 7'b0000000) begin
                errors++;
                $display("FAIL reset[%0d]: got %b expected %b", n, crcf, 7'b0000000);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (crcf !== 7'b1111110) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", crcf, 7'b1111110);
        end
    endtask

    task automatic test_sweep();
        logic [6:0] exp_tab [7] = '{7'b0000000, 7'b0000111, 7'b0001001, 7'b0001110,
                                    7'b0010010, 7'b0010101, 7'b0011011};
        gp = 3'b111;
        for (int n = 0; n < 7; n++) begin
            msg = 7'(n);
            step();
            checks++;
            if (crcf !== exp_tab[n]) begin
                errors++;
                $display("FAIL sweep[%0d]: got %b expected %b", n, crcf, exp_tab[n]);
            end
        end
    endtask

    task automatic test_gen_change();
        gp = 3'b101; msg = 7'b0000010;
        step();
        checks++;
        if (crcf !== 7'b0001010) begin
            errors++;
            $display("FAIL gen_change: got %b expected %b", crcf, 7'b0001010);
        end
    endtask

    task automatic test_ignored_bits();
        logic [6:0] msgs [2] = '{7'b1100001, 7'b0000001};
        gp = 3'b111;
        for (int n = 0; n < 2; n++) begin
            msg = msgs[n];
            step();
            checks++;
            if (crcf !== 7'b0000111) begin
                errors++;
                $display("FAIL ignored_bits[%0d]: got %b expected %b", n, crcf, 7'b0000111);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        gp = 3'b111;
        for (int n = 0; n < 30; n++) begin
            msg = 7'($urandom);
            gp  = 3'($urandom);
            rst = (n == 15);
            exp = rst ? 7'b0000000 : ref_crc(msg, gp);
            step();
            checks++;
            if (crcf !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b expected %b (msg %b gp %b rst %b)",
                         n, crcf, exp, msg, gp, rst);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] exp;
        for (int n = 0; n < 1000; n++) begin
            msg = 7'($urandom);
            gp  = 3'($urandom);
            exp = ref_crc(msg, gp);
            step();
            checks++;
            if (crcf !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got %b expected %b (msg %b gp %b)", n, crcf, exp, msg, gp);
            end
            checks++;
            if (crcf[6:2] !== msg[4:0]) begin
                errors++;
                $display("FAIL systematic[%0d]: got %b expected %b", n, crcf[6:2], msg[4:0]);
            end
        end
    endtask

    task automatic test_linearity();
        logic [6:0] a, b;
        logic [1:0] ra, rb;
        for (int n = 0; n < 200; n++) begin
            a  = 7'($urandom);
            b  = 7'($urandom);
            gp = 3'($urandom);
            msg = a;     step(); ra = crcf[1:0];
            msg = b;     step(); rb = crcf[1:0];
            msg = a ^ b; step();
            checks++;
            if (crcf[1:0] !== (ra ^ rb)) begin
                errors++;
                $display("FAIL linearity[%0d]: got %b expected %b (a %b b %b gp %b)",
                         n, crcf[1:0], ra ^ rb, a, b, gp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; msg = '0; gp = 3'b111;
        test_reset();
        test_sweep();
        test_gen_change();
        test_ignored_bits();
        test_back_to_back();
        test_random();
        test_linearity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
